// File: rtl/fano_sim_pkg.sv
// Shared types and constants for the symbol error checker.
// Holds the FSM state type, symbol width and default counter width.
package fano_sim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned SYM_W     = 2;
  localparam int unsigned DEF_CNT_W = 32;

  // Number of set bits in a 2-bit symbol mask (0, 1 or 2).
  function automatic logic [1:0] popcnt2(input logic [SYM_W-1:0] m);
    return {1'b0, m[0]} + {1'b0, m[1]};
  endfunction

endpackage

// File: rtl/err_ref_fifo.sv
// Reference-symbol buffer: synchronous FIFO with show-ahead head and flush.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module err_ref_fifo
  import fano_sim_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [SYM_W-1:0] wdata_i,
  input  logic             pop_i,
  output logic [SYM_W-1:0] head_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [SYM_W-1:0] mem_q [DEPTH];
  logic             do_push_c;
  logic             do_pop_c;

  // Extra pointer MSB distinguishes full from empty.
  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_c  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop_c  = pop_i && !empty_c;
    do_push_c = push_i && (!full_c || do_pop_c);
    wr_ptr_d  = wr_ptr_q + (AW+1)'(do_push_c);
    rd_ptr_d  = rd_ptr_q + (AW+1)'(do_pop_c);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c && !flush_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/err_checker.sv
// Symbol error checker: compares a received 2-bit stream against a buffered
// reference stream over a fixed-length window and accumulates error statistics.
module err_checker
  import fano_sim_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_win_len,
  input  logic             i_ref_vld,
  input  logic [SYM_W-1:0] i_ref_word,
  input  logic             i_rx_vld,
  input  logic [SYM_W-1:0] i_rx_word,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_words,
  output logic [CNT_W-1:0] o_bit_err,
  output logic [CNT_W-1:0] o_word_err,
  output logic [CNT_W-1:0] o_first_err,
  output logic             o_err_pulse,
  output logic [SYM_W-1:0] o_err_mask,
  output logic             o_ovf,
  output logic             o_udf
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] win_len_q, win_len_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic [CNT_W-1:0] bit_err_q, bit_err_d;
  logic [CNT_W-1:0] word_err_q, word_err_d;
  logic [CNT_W-1:0] first_err_q, first_err_d;
  logic             err_pulse_q, err_pulse_d;
  logic [SYM_W-1:0] err_mask_q, err_mask_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             push_c, pop_c, flush_c;
  logic [SYM_W-1:0] head_c, mask_c;
  logic             full_c, empty_c;
  logic [CNT_W:0]   bit_sum_c;

  err_ref_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush_c),
    .push_i  (push_c),
    .wdata_i (i_ref_word),
    .pop_i   (pop_c),
    .head_c  (head_c),
    .full_c  (full_c),
    .empty_c (empty_c)
  );

  always_comb begin
    state_d     = state_q;
    win_len_d   = win_len_q;
    words_d     = words_q;
    bit_err_d   = bit_err_q;
    word_err_d  = word_err_q;
    first_err_d = first_err_q;
    err_pulse_d = 1'b0;
    err_mask_d  = '0;
    ovf_d       = ovf_q;
    udf_d       = udf_q;
    push_c      = 1'b0;
    pop_c       = 1'b0;
    flush_c     = 1'b0;
    mask_c      = head_c ^ i_rx_word;
    bit_sum_c   = {1'b0, bit_err_q} + (CNT_W+1)'(popcnt2(mask_c));

    case (state_q)
      RUN: begin
        // Stream inputs only matter while the window is still open.
        if (words_q != win_len_q) begin
          push_c = i_ref_vld;
          pop_c  = i_rx_vld;
          if (i_ref_vld && full_c && !i_rx_vld) ovf_d = 1'b1;
          if (i_rx_vld && empty_c) udf_d = 1'b1;
          if (i_rx_vld && !empty_c) begin
            words_d   = (&words_q) ? words_q : words_q + CNT_W'(1);
            bit_err_d = bit_sum_c[CNT_W] ? '1 : bit_sum_c[CNT_W-1:0];
            if (mask_c != '0) begin
              err_pulse_d = 1'b1;
              err_mask_d  = mask_c;
              // Saturating word_err is zero only before the first error.
              if (word_err_q == '0) first_err_d = words_q;
              word_err_d = (&word_err_q) ? word_err_q : word_err_q + CNT_W'(1);
            end
          end
        end
        if (words_d == win_len_q) state_d = DONE;
      end
      IDLE, DONE: ;
      default: state_d = IDLE;
    endcase

    // A start pulse restarts from any state and discards that cycle's stream.
    if (i_start) begin
      state_d     = RUN;
      win_len_d   = i_win_len;
      words_d     = '0;
      bit_err_d   = '0;
      word_err_d  = '0;
      first_err_d = '1;
      err_pulse_d = 1'b0;
      err_mask_d  = '0;
      ovf_d       = 1'b0;
      udf_d       = 1'b0;
      push_c      = 1'b0;
      pop_c       = 1'b0;
      flush_c     = 1'b1;
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      win_len_q   <= '0;
      words_q     <= '0;
      bit_err_q   <= '0;
      word_err_q  <= '0;
      first_err_q <= '1;
      err_pulse_q <= 1'b0;
      err_mask_q  <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_len_q   <= win_len_d;
      words_q     <= words_d;
      bit_err_q   <= bit_err_d;
      word_err_q  <= word_err_d;
      first_err_q <= first_err_d;
      err_pulse_q <= err_pulse_d;
      err_mask_q  <= err_mask_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_words     = words_q;
  assign o_bit_err   = bit_err_q;
  assign o_word_err  = word_err_q;
  assign o_first_err = first_err_q;
  assign o_err_pulse = err_pulse_q;
  assign o_err_mask  = err_mask_q;
  assign o_ovf       = ovf_q;
  assign o_udf       = udf_q;

endmodule

// File: tb/tb_err_checker.sv
// Self-checking bench for err_checker: table-driven windows, hand-written corner
// sequences and randomized traffic, all checked against a queue-based model.
module tb_err_checker;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned DEPTH = 16;
  localparam logic [63:0] ALL1  = 64'h0000_0000_FFFF_FFFF;

  logic             clk = 1'b0;
  logic             reset, i_start, i_ref_vld, i_rx_vld;
  logic [CNT_W-1:0] i_win_len;
  logic [1:0]       i_ref_word, i_rx_word;
  logic             o_busy, o_done, o_err_pulse, o_ovf, o_udf;
  logic [CNT_W-1:0] o_words, o_bit_err, o_word_err, o_first_err;
  logic [1:0]       o_err_mask;

  always #5 clk = ~clk;

  err_checker #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_win_len(i_win_len),
    .i_ref_vld(i_ref_vld), .i_ref_word(i_ref_word),
    .i_rx_vld(i_rx_vld), .i_rx_word(i_rx_word),
    .o_busy(o_busy), .o_done(o_done), .o_words(o_words), .o_bit_err(o_bit_err),
    .o_word_err(o_word_err), .o_first_err(o_first_err),
    .o_err_pulse(o_err_pulse), .o_err_mask(o_err_mask),
    .o_ovf(o_ovf), .o_udf(o_udf)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural reference: a queue of pending reference symbols and plain counts.
  bit              m_busy, m_done, m_pulse, m_ovf, m_udf;
  logic [1:0]      m_mask;
  longint unsigned m_words, m_bit, m_werr, m_first, m_len;
  logic [1:0]      m_q[$];

  typedef struct {
    string           name;
    int              win;
    int              first_idx;
    int              period;
    logic [1:0]      flip;
    longint unsigned exp_words, exp_bit, exp_werr, exp_first;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_words = 0; m_bit = 0; m_werr = 0; m_first = ALL1;
    m_ovf = 0; m_udf = 0; m_pulse = 0; m_mask = 2'b00;
    m_q.delete();
  endtask

  task automatic model_step(input bit rst, input bit st, input longint unsigned wl,
                            input bit rv, input logic [1:0] rw,
                            input bit xv, input logic [1:0] xw);
    logic [1:0] h, d;
    m_pulse = 0;
    m_mask  = 2'b00;
    if (rst) begin
      model_clear();
      m_busy = 0; m_done = 0; m_len = 0;
    end else if (st) begin
      model_clear();
      m_busy = 1; m_done = 0; m_len = wl;
    end else if (m_busy) begin
      if (m_words < m_len) begin
        if (xv) begin
          if (m_q.size() == 0) m_udf = 1;
          else begin
            h = m_q.pop_front();
            d = h ^ xw;
            m_words++;
            m_bit += longint'($countones(d));
            if (d != 2'b00) begin
              if (m_werr == 0) m_first = m_words - 1;
              m_werr++;
              m_pulse = 1;
              m_mask  = d;
            end
          end
        end
        if (rv) begin
          if (m_q.size() == DEPTH) m_ovf = 1;
          else m_q.push_back(rw);
        end
      end
      if (m_words >= m_len) begin
        m_busy = 0; m_done = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".busy"},  64'(o_busy),      64'(m_busy));
    chk({tag, ".done"},  64'(o_done),      64'(m_done));
    chk({tag, ".words"}, 64'(o_words),     m_words);
    chk({tag, ".bit"},   64'(o_bit_err),   m_bit);
    chk({tag, ".werr"},  64'(o_word_err),  m_werr);
    chk({tag, ".first"}, 64'(o_first_err), m_first);
    chk({tag, ".pulse"}, 64'(o_err_pulse), 64'(m_pulse));
    chk({tag, ".mask"},  64'(o_err_mask),  64'(m_mask));
    chk({tag, ".ovf"},   64'(o_ovf),       64'(m_ovf));
    chk({tag, ".udf"},   64'(o_udf),       64'(m_udf));
  endtask

  // One clock: drive inputs, advance the model, sample 1ns after the edge.
  task automatic cyc(input string tag, input bit rst, input bit st, input int wl,
                     input bit rv, input logic [1:0] rw,
                     input bit xv, input logic [1:0] xw);
    reset = rst; i_start = st; i_win_len = CNT_W'(wl);
    i_ref_vld = rv; i_ref_word = rw; i_rx_vld = xv; i_rx_word = xw;
    model_step(rst, st, longint'(wl), rv, rw, xv, xw);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  vec_t       vecs[5];
  logic [1:0] refw[256];

  initial begin
    bit         corrupt;
    int         pct;
    logic [1:0] x, r;

    m_busy = 0; m_done = 0; m_len = 0;
    model_clear();
    reset = 1; i_start = 0; i_win_len = '0;
    i_ref_vld = 0; i_ref_word = 0; i_rx_vld = 0; i_rx_word = 0;

    vecs[0] = '{"clean100",  100, -1, 0, 2'b00, 100, 0, 0, ALL1};
    vecs[1] = '{"every8",     50, 10, 8, 2'b01,  50, 5, 5, 10};
    vecs[2] = '{"both_bits",   8,  3, 0, 2'b11,   8, 2, 1, 3};
    vecs[3] = '{"win0",        0, -1, 0, 2'b00,   0, 0, 0, ALL1};
    vecs[4] = '{"all_err",    20,  0, 1, 2'b10,  20, 20, 20, 0};

    // Reset state.
    cyc("rst", 1, 0, 0, 0, 0, 0, 0);
    cyc("rst", 1, 0, 0, 0, 0, 0, 0);
    chk("rst_first", 64'(o_first_err), ALL1);
    chk("rst_busy", 64'(o_busy), 64'd0);

    // Table-driven windows; rx trails ref by one cycle.
    foreach (vecs[v]) begin
      for (int i = 0; i < 256; i++) refw[i] = 2'($urandom);
      cyc({vecs[v].name, ".start"}, 0, 1, vecs[v].win, 0, 0, 0, 0);
      for (int i = 0; i < 250; i++) begin
        x = 2'b00;
        if (i >= 1) begin
          corrupt = (vecs[v].first_idx >= 0) && (i - 1 >= vecs[v].first_idx) &&
                    ((vecs[v].period == 0) ? (i - 1 == vecs[v].first_idx)
                                           : ((i - 1 - vecs[v].first_idx) % vecs[v].period == 0));
          x = refw[(i - 1) % 256] ^ (corrupt ? vecs[v].flip : 2'b00);
        end
        cyc(vecs[v].name, 0, 0, 0, 1, refw[i % 256], i >= 1, x);
        if (o_done) break;
      end
      chk({vecs[v].name, ".done_reached"}, 64'(o_done), 64'd1);
      chk({vecs[v].name, ".words"}, 64'(o_words), vecs[v].exp_words);
      chk({vecs[v].name, ".bit"},   64'(o_bit_err), vecs[v].exp_bit);
      chk({vecs[v].name, ".werr"},  64'(o_word_err), vecs[v].exp_werr);
      chk({vecs[v].name, ".first"}, 64'(o_first_err), vecs[v].exp_first);
      for (int i = 0; i < 3; i++) cyc("done_hold", 0, 0, 0, 1, 2'($urandom), 1, 2'($urandom));
    end

    // Underflow: two rx words before any ref, then four matched words.
    for (int i = 0; i < 8; i++) refw[i] = 2'($urandom);
    cyc("udf.start", 0, 1, 10, 0, 0, 0, 0);
    cyc("udf", 0, 0, 0, 0, 0, 1, 2'b01);
    cyc("udf", 0, 0, 0, 1, refw[0], 1, 2'b10);
    for (int i = 1; i < 4; i++) cyc("udf", 0, 0, 0, 1, refw[i], 0, 0);
    for (int i = 0; i < 4; i++) cyc("udf", 0, 0, 0, 0, 0, 1, refw[i]);
    chk("udf_flag", 64'(o_udf), 64'd1);
    chk("udf_words", 64'(o_words), 64'd4);
    chk("udf_werr", 64'(o_word_err), 64'd0);

    // Overflow: 20 pushes into a 16-deep buffer, then drain the kept 16.
    for (int i = 0; i < 20; i++) refw[i] = 2'($urandom);
    cyc("ovf.start", 0, 1, 100, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc("ovf", 0, 0, 0, 1, refw[i], 0, 0);
    chk("ovf_flag", 64'(o_ovf), 64'd1);
    for (int i = 0; i < 16; i++) cyc("ovf", 0, 0, 0, 0, 0, 1, refw[i]);
    chk("ovf_words", 64'(o_words), 64'd16);
    chk("ovf_werr", 64'(o_word_err), 64'd0);

    // Restart mid-run with stream activity on the start cycle.
    cyc("rs.start", 0, 1, 20, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc("rs", 0, 0, 0, 1, 2'b00, i > 0, 2'b11);
    cyc("rs.restart", 0, 1, 6, 1, 2'b01, 1, 2'b10);
    chk("rs_words_cleared", 64'(o_words), 64'd0);
    for (int i = 0; i < 8; i++) cyc("rs", 0, 0, 0, 1, 2'b01, i > 0, 2'b01);
    chk("rs_done", 64'(o_done), 64'd1);
    chk("rs_words", 64'(o_words), 64'd6);

    // Reset at word 30 of a 100-word window.
    cyc("ra.start", 0, 1, 100, 0, 0, 0, 0);
    for (int i = 0; i <= 30; i++) cyc("ra", 0, 0, 0, 1, 2'b10, i > 0, 2'b11);
    cyc("ra.reset", 1, 0, 0, 1, 2'b10, 1, 2'b11);
    chk("ra_words", 64'(o_words), 64'd0);
    chk("ra_first", 64'(o_first_err), ALL1);
    for (int i = 0; i < 4; i++) begin
      cyc("ra.idle", 0, 0, 0, 1, 2'b10, 1, 2'b10);
      chk("ra_no_done", 64'(o_done), 64'd0);
    end

    // Randomized windows, including restarts and occasional resets.
    for (int w = 0; w < 30; w++) begin
      pct = (w % 3 == 0) ? 25 : ((w % 3 == 1) ? 60 : 90);
      cyc("rnd.start", 0, 1, $urandom_range(0, 40), 0, 0, 0, 0);
      for (int c = 0; c < 70; c++) begin
        r = (m_q.size() > 0) ? m_q[0] : 2'($urandom);
        x = r ^ (($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00);
        cyc("rnd", ($urandom_range(0, 399) == 0), 0, 0,
            ($urandom_range(0, 99) < 70), 2'($urandom),
            ($urandom_range(0, 99) < pct), x);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/err_checker.md
ERR_CHECKER -- requirements
Module: err_checker

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, reference-word buffer depth (power of 2, 4..64).
REQ-002 Parameter CNT_W, default 32, width of all counters and i_win_len.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i_start  input  1  one-cycle pulse; clears results and starts a measurement window.
REQ-006 i_win_len  input  CNT_W  window length in compared words; sampled on i_start.
REQ-007 i_ref_vld / i_ref_word  input  1 / 2  clean (pre-channel) 2-bit symbol stream.
REQ-008 i_rx_vld / i_rx_word  input  1 / 2  received (post-channel) 2-bit symbol stream, same order.
REQ-009 o_busy  output  1  high in RUN.
REQ-010 o_done  output  1  high in DONE; results stable.
REQ-011 o_words, o_bit_err, o_word_err  output  CNT_W each  compared words, errored bits, errored words.
REQ-012 o_first_err  output  CNT_W  0-based index of first errored word; all-ones if none.
REQ-013 o_err_pulse / o_err_mask  output  1 / 2  per-word error strobe and XOR mask.
REQ-014 o_ovf / o_udf  output  1 each  sticky FIFO overflow / underflow flags.

Function
REQ-015 FSM states IDLE, RUN, DONE; after reset SHALL be IDLE.
REQ-016 IDLE->RUN on i_start: counters zeroed, o_first_err set all-ones, FIFO flushed, flags cleared, i_win_len latched.
REQ-017 i_start in RUN or DONE SHALL restart identically (counters cleared, RUN re-entered); stream words on the i_start cycle SHALL be discarded.
REQ-018 Latched window length 0 SHALL go RUN->DONE on the next cycle with all counts zero.
REQ-019 In RUN, i_ref_vld SHALL push i_ref_word; i_rx_vld SHALL pop the FIFO head and compare with i_rx_word.
REQ-020 Per comparison: mask = head XOR rx; o_words +1; o_bit_err + popcount(mask) (0,1,2); o_word_err +1 if mask nonzero.
REQ-021 o_err_pulse and o_err_mask SHALL be registered, valid exactly 1 cycle after the i_rx_vld cycle, pulse only when mask nonzero; mask 0 otherwise.
REQ-022 o_first_err SHALL capture the o_words value (pre-increment) at the first nonzero mask of the window, then hold.
REQ-023 Counters SHALL saturate at all-ones, never wrap.
REQ-024 Push while full with no simultaneous pop: word dropped, o_ovf set. Push+pop while full: both accepted.
REQ-025 Pop while empty (including simultaneous push on empty): rx word dropped, not counted, o_udf set; the pushed word still enters the FIFO.
REQ-026 RUN->DONE in the cycle after the comparison that makes o_words equal the latched length; later stream inputs ignored.
REQ-027 Outside RUN, stream valids SHALL have no effect; in DONE, all result outputs hold until i_start or reset.

Reset
REQ-028 reset SHALL force IDLE; o_busy, o_done, o_err_pulse, o_ovf, o_udf 0; o_err_mask 0; counters 0; o_first_err all-ones; FIFO empty.
REQ-029 reset mid-RUN SHALL abort the window with no o_done assertion.

Structure
REQ-030 Package fano_sim_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE), the symbol width constant (2) and the default CNT_W.
REQ-031 The buffer SHALL be a sub-module err_ref_fifo: synchronous, show-ahead head, full/empty outputs, flush input.

Verification
REQ-032 Win 100, ref==rx every cycle, no corruption -> o_done, o_words=100, bit/word errors 0, o_first_err=all-ones, no pulses.
REQ-033 Win 50, rx bit0 inverted on word 10 and every 8th word after (10,18,...,42) -> o_word_err=5, o_bit_err=5, o_first_err=10, pulses 1 cycle after each.
REQ-034 Word 3 with both bits inverted, win 8 -> o_err_mask=2'b11, o_bit_err=2, o_word_err=1.
REQ-035 rx leads ref by 2 cycles from empty -> o_udf=1, first two rx words uncounted; 20 ref pushes with no rx at depth 16 -> o_ovf=1.
REQ-036 Win 0 -> DONE next cycle, counts 0; reset asserted at word 30 of win 100 -> IDLE, all outputs at reset values, no o_done.
